// File: rtl/bsg_wormhole_packet_tx.sv
// Wormhole transmit endpoint: turns a packet descriptor plus body flits into a
// header flit followed by len body flits, staged through a 2-entry output buffer.
module bsg_wormhole_packet_tx #(
    parameter int flit_width_p  = 32,
    parameter int len_width_p   = 4,
    parameter int cid_width_p   = 2,
    parameter int cord_width_p  = 5,
    localparam int hdr_data_width_lp = flit_width_p - len_width_p - cid_width_p - cord_width_p,
    // link layout, MSB first: {v, ready_and_rev, data}
    localparam int link_width_lp = flit_width_p + 2
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         pkt_v_i,
    input  logic [cord_width_p-1:0]      pkt_cord_i,
    input  logic [cid_width_p-1:0]       pkt_cid_i,
    input  logic [len_width_p-1:0]       pkt_len_i,
    input  logic [hdr_data_width_lp-1:0] pkt_data_i,
    output logic                         pkt_ready_and_o,
    input  logic                         data_v_i,
    input  logic [flit_width_p-1:0]      data_i,
    output logic                         data_ready_and_o,
    input  logic [link_width_lp-1:0]     link_i,
    output logic [link_width_lp-1:0]     link_o,
    output logic                         busy_o
);

    typedef enum logic {IDLE, BODY} state_e;

    state_e                  state_r, state_n;
    logic [len_width_p-1:0]  remaining_r, remaining_n;

    logic [1:0][flit_width_p-1:0] mem_r;
    logic                         rd_ptr_r, wr_ptr_r;
    logic [1:0]                   count_r;
    logic                         full, empty, enq_v, deq;
    logic [flit_width_p-1:0]      enq_data;

    logic link_ready;
    logic link_unused;

    assign link_ready  = link_i[flit_width_p];
    assign link_unused = ^{link_i[flit_width_p+1], link_i[flit_width_p-1:0]};

    assign full  = (count_r == 2'd2);
    assign empty = (count_r == 2'd0);
    assign deq   = ~empty & link_ready & ~reset_i;

    always_comb begin
        state_n          = state_r;
        remaining_n      = remaining_r;
        pkt_ready_and_o  = 1'b0;
        data_ready_and_o = 1'b0;
        enq_v            = 1'b0;
        enq_data         = {pkt_data_i, pkt_len_i, pkt_cid_i, pkt_cord_i};
        case (state_r)
            IDLE: begin
                pkt_ready_and_o = ~full & ~reset_i;
                if (pkt_v_i & pkt_ready_and_o) begin
                    enq_v = 1'b1;
                    if (pkt_len_i != '0) begin
                        state_n     = BODY;
                        remaining_n = pkt_len_i;
                    end
                end
            end
            BODY: begin
                data_ready_and_o = ~full & ~reset_i;
                enq_data         = data_i;
                if (data_v_i & data_ready_and_o) begin
                    enq_v       = 1'b1;
                    remaining_n = remaining_r - 1'b1;
                    if (remaining_r == len_width_p'(1))
                        state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r     <= IDLE;
            remaining_r <= '0;
            rd_ptr_r    <= 1'b0;
            wr_ptr_r    <= 1'b0;
            count_r     <= 2'd0;
        end else begin
            state_r     <= state_n;
            remaining_r <= remaining_n;
            if (enq_v) wr_ptr_r <= ~wr_ptr_r;
            if (deq)   rd_ptr_r <= ~rd_ptr_r;
            case ({enq_v, deq})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    // storage needs no reset; occupancy alone decides what is visible
    always_ff @(posedge clk_i) begin
        if (enq_v) mem_r[wr_ptr_r] <= enq_data;
    end

    assign link_o = {~empty & ~reset_i, 1'b0, mem_r[rd_ptr_r]};
    assign busy_o = ((state_r == BODY) | ~empty) & ~reset_i;

    // a descriptor held while stalled must keep its fields steady
    a_pkt_stable: assert property (@(posedge clk_i) disable iff (reset_i)
        (pkt_v_i && !pkt_ready_and_o) |=>
        (!pkt_v_i || $stable({pkt_cord_i, pkt_cid_i, pkt_len_i, pkt_data_i})));

endmodule

// File: tb/tb_bsg_wormhole_packet_tx.sv
// Randomized bench for bsg_wormhole_packet_tx: an expected-flit queue built from
// packet contents, plus a handshake-level occupancy scoreboard.
module tb_bsg_wormhole_packet_tx;
    localparam int FW = 32, LW = 4, CW = 2, DW = 5, HW = FW - LW - CW - DW, KW = FW + 2;

    logic          clk = 1'b0;
    logic          reset_i = 1'b1;
    logic          pkt_v_i = 1'b0;
    logic [DW-1:0] pkt_cord_i = '0;
    logic [CW-1:0] pkt_cid_i = '0;
    logic [LW-1:0] pkt_len_i = '0;
    logic [HW-1:0] pkt_data_i = '0;
    logic          pkt_ready_and_o;
    logic          data_v_i = 1'b0;
    logic [FW-1:0] data_i = '0;
    logic          data_ready_and_o;
    logic [KW-1:0] link_i, link_o;
    logic          busy_o;

    logic          link_ready = 1'b1;
    logic          noise_on = 1'b0;
    logic          noise_v = 1'b0;
    logic [FW-1:0] noise_data = '0;
    int            mode = 1;  // 0 stuck, 1 ready, 2 toggle, 3 random

    assign link_i = {noise_v, link_ready, noise_data};

    bsg_wormhole_packet_tx #(.flit_width_p(FW), .len_width_p(LW), .cid_width_p(CW), .cord_width_p(DW)) dut (
        .clk_i(clk), .reset_i(reset_i),
        .pkt_v_i(pkt_v_i), .pkt_cord_i(pkt_cord_i), .pkt_cid_i(pkt_cid_i),
        .pkt_len_i(pkt_len_i), .pkt_data_i(pkt_data_i), .pkt_ready_and_o(pkt_ready_and_o),
        .data_v_i(data_v_i), .data_i(data_i), .data_ready_and_o(data_ready_and_o),
        .link_i(link_i), .link_o(link_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0, cyc = 0, occ = 0, ndeliv = 0;
    logic [FW-1:0] exp_q[$];
    int            xfer_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [FW-1:0] mk_hdr(logic [DW-1:0] cord, logic [CW-1:0] cid,
                                             logic [LW-1:0] len, logic [HW-1:0] d);
        return {d, len, cid, cord};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        case (mode)
            0: link_ready = 1'b0;
            1: link_ready = 1'b1;
            2: link_ready = ~link_ready;
            default: link_ready = 1'($urandom_range(0, 1));
        endcase
        noise_v    = noise_on ? 1'($urandom_range(0, 1)) : 1'b0;
        noise_data = noise_on ? $urandom : '0;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_acc(input bit is_pkt, input string tag);
        bit acc;
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            acc = is_pkt ? pkt_ready_and_o : data_ready_and_o;
            tick();
            if (acc) return;
        end
        chk(tag, 0, 1);
    endtask

    task automatic offer_pkt(input logic [DW-1:0] cord, input logic [CW-1:0] cid,
                             input logic [LW-1:0] len, input logic [HW-1:0] d);
        exp_q.push_back(mk_hdr(cord, cid, len, d));
        pkt_cord_i = cord; pkt_cid_i = cid; pkt_len_i = len; pkt_data_i = d;
        pkt_v_i = 1'b1;
        wait_acc(1'b1, "pkt_timeout");
        pkt_v_i = 1'b0;
    endtask

    task automatic offer_body(input logic [FW-1:0] d);
        exp_q.push_back(d);
        data_i = d;
        data_v_i = 1'b1;
        wait_acc(1'b0, "data_timeout");
        data_v_i = 1'b0;
    endtask

    task automatic send_pkt(input logic [LW-1:0] len);
        offer_pkt(DW'($urandom), CW'($urandom), len, HW'($urandom));
        for (int i = 0; i < int'(len); i++) offer_body($urandom);
    endtask

    // link monitor and occupancy scoreboard
    initial forever begin
        bit enq, deq;
        @(negedge clk);
        if (reset_i) begin
            occ = 0;
            continue;
        end
        enq = (pkt_v_i & pkt_ready_and_o) | (data_v_i & data_ready_and_o);
        deq = link_o[FW+1] & link_ready;
        chk("vld_occ", link_o[FW+1], occ != 0);
        chk("rev_zero", link_o[FW], 0);
        if (occ == 2) chk("rdy_full", {pkt_ready_and_o, data_ready_and_o}, 0);
        if (deq) begin
            xfer_cyc.push_back(cyc);
            ndeliv++;
            if (exp_q.size() == 0) chk("extra_flit", link_o[FW-1:0], 'x);
            else chk("flit", link_o[FW-1:0], exp_q.pop_front());
        end
        occ = occ + int'(enq) - int'(deq);
    end

    task automatic run_s2();
        xfer_cyc.delete();
        data_v_i = 1'b1;
        data_i = $urandom;
        #1;
        chk("data_rdy_idle", data_ready_and_o, 0);
        tick();
        data_v_i = 1'b0;
        send_pkt(4'd3);
        send_pkt(4'd0);
        drain(4);
        chk("s2_count", xfer_cyc.size(), 5);
        for (int i = 0; i + 1 < xfer_cyc.size(); i++)
            chk("s2_gap", xfer_cyc[i+1] - xfer_cyc[i], 1);
        chk("s2_empty", exp_q.size(), 0);
    endtask

    initial begin
        // reset state
        drain(3);
        @(negedge clk);
        chk("rst_v", link_o[FW+1], 0);
        chk("rst_rev", link_o[FW], 0);
        chk("rst_rdy", {pkt_ready_and_o, data_ready_and_o}, 0);
        chk("rst_busy", busy_o, 0);
        tick();
        reset_i = 1'b0;
        #1;
        chk("post_rst_prdy", pkt_ready_and_o, 1);
        chk("post_rst_busy", busy_o, 0);

        // header-only packet, latency one cycle
        offer_pkt(5'h3, 2'd2, 4'd0, 21'h1);
        chk("s1_v", link_o[FW+1], 1);
        chk("s1_hdr", link_o[FW-1:0], 32'h0000_0843);
        chk("s1_prdy", pkt_ready_and_o, 1);
        tick();
        chk("s1_busy", busy_o, 0);

        // back-to-back packets, no bubbles
        run_s2();

        // max length with toggling link
        mode = 2;
        ndeliv = 0;
        send_pkt(4'd15);
        drain(40);
        chk("s3_count", ndeliv, 16);
        chk("s3_empty", exp_q.size(), 0);

        // stuck link fills the buffer, then drains
        mode = 0;
        link_ready = 1'b0;
        send_pkt(4'd1);
        drain(2);
        chk("s4_rdy", {pkt_ready_and_o, data_ready_and_o}, 0);
        chk("s4_v", link_o[FW+1], 1);
        chk("s4_busy", busy_o, 1);
        mode = 1;
        link_ready = 1'b1;
        drain(2);
        chk("s4_drained_v", link_o[FW+1], 0);
        chk("s4_drained_busy", busy_o, 0);
        chk("s4_empty", exp_q.size(), 0);

        // reset in the middle of a packet
        offer_pkt(DW'($urandom), CW'($urandom), 4'd4, HW'($urandom));
        offer_body($urandom);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        exp_q.delete();
        #1;
        chk("s5_v", link_o[FW+1], 0);
        chk("s5_busy", busy_o, 0);
        chk("s5_idle", {pkt_ready_and_o, data_ready_and_o}, 2'b10);
        ndeliv = 0;
        send_pkt(4'd1);
        drain(4);
        chk("s5_count", ndeliv, 2);
        chk("s5_empty", exp_q.size(), 0);

        // scenario 2 again with noise on the ignored link inputs
        noise_on = 1'b1;
        run_s2();
        noise_on = 1'b0;

        // random lengths under random backpressure
        mode = 3;
        for (int p = 0; p < 8; p++) send_pkt(LW'($urandom));
        mode = 1;
        drain(10);
        chk("rand_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
